// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one dual-port data memory among N_REQ load/store units.
// It supports read, write and a two-cycle atomic fetch-and-add that uses the write port on its second cycle.
module data_mem_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    input  logic [2*N_REQ-1:0]      op,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*32-1:0]     wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [31:0]             rdata,
    output logic [ADDR_W-1:0]       mem_addra,
    output logic [31:0]             mem_dina,
    output logic                    mem_wea,
    output logic [ADDR_W-1:0]       mem_addrb,
    input  logic [31:0]             mem_doutb
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        ISSUE  = 1'b0,
        AMO_WB = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]    rvalid_q, rvalid_d;
    logic [ADDR_W-1:0]   aaddr_q, aaddr_d;
    logic [31:0]         aadd_q, aadd_d;

    logic                grant_vld;
    logic [PTR_W-1:0]    grant_idx;
    logic [N_REQ-1:0]    grant_onehot;
    logic                issue;
    logic [1:0]          op_g;
    logic [ADDR_W-1:0]   addr_g;
    logic [31:0]         wdata_g;
    logic                is_write;
    logic                is_amo;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    // First requester at or after rr_ptr, searching cyclically.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_vld && req[wrap_idx(rr_ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_idx(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        grant_onehot = N_REQ'(1) << grant_idx;
        op_g         = op[2*int'(grant_idx) +: 2];
        addr_g       = addr[ADDR_W*int'(grant_idx) +: ADDR_W];
        wdata_g      = wdata[32*int'(grant_idx) +: 32];
        is_write     = (op_g == 2'b01);
        is_amo       = (op_g == 2'b10);
        issue        = rstn && (state_q == ISSUE) && grant_vld;
    end

    // Reset forces gnt and mem_wea low combinationally, which also abandons a pending write-back.
    always_comb begin
        gnt       = issue ? grant_onehot : '0;
        rvalid    = rvalid_q;
        rdata     = mem_doutb;
        mem_addrb = (state_q == AMO_WB) ? aaddr_q : addr_g;
        mem_addra = (state_q == AMO_WB) ? aaddr_q : addr_g;
        mem_dina  = (state_q == AMO_WB) ? (mem_doutb + aadd_q) : wdata_g;
        mem_wea   = rstn && ((state_q == AMO_WB) || (issue && is_write));
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        rvalid_d = '0;
        aaddr_d  = aaddr_q;
        aadd_d   = aadd_q;
        if (state_q == AMO_WB) begin
            state_d = ISSUE;
        end else if (issue) begin
            rr_ptr_d = wrap_idx(grant_idx, 1);
            if (!is_write) rvalid_d = grant_onehot;
            if (is_amo) begin
                state_d = AMO_WB;
                aaddr_d = addr_g;
                aadd_d  = wdata_g;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ISSUE;
            rr_ptr_q <= '0;
            rvalid_q <= '0;
            aaddr_q  <= '0;
            aadd_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
            aaddr_q  <= aaddr_d;
            aadd_q   <= aadd_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios followed by random traffic against a sequential memory model.
module tb_data_mem_arbiter;
    localparam int N  = 2;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req;
    logic [2*N-1:0]    op;
    logic [N*AW-1:0]   addr;
    logic [N*32-1:0]   wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [31:0]       rdata;
    logic [AW-1:0]     mem_addra;
    logic [31:0]       mem_dina;
    logic              mem_wea;
    logic [AW-1:0]     mem_addrb;
    logic [31:0]       mem_doutb;

    logic [31:0]       mem [16];
    logic              bd_we;
    logic [AW-1:0]     bd_addr;
    logic [31:0]       bd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.N_REQ(N), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_wea(mem_wea),
        .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
    );

    // Dual-port memory with registered read; the bench backdoor takes priority.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_wea) mem[mem_addra] <= mem_dina;
        mem_doutb <= mem[mem_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic [1:0] o,
                           input logic [AW-1:0] a, input logic [31:0] d);
        req[i]           = r;
        op[2*i +: 2]     = o;
        addr[AW*i +: AW] = a;
        wdata[32*i +: 32] = d;
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    logic [31:0]   ref_mem [16];
    bit            pend [N];
    logic [1:0]    r_op [N];
    logic [AW-1:0] r_addr [N];
    logic [31:0]   r_wd [N];
    int            model_ptr;
    bit            model_busy;
    logic [N-1:0]  exp_rv;
    logic [31:0]   exp_rd;
    logic [N-1:0]  exp_g;
    int            g;

    initial begin
        rstn = 1'b0; req = '0; op = '0; addr = '0; wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        for (int i = 0; i < 16; i++) bd_write(AW'(i), 32'h0);
        bd_write(4'd5, 32'hDEADBEEF);
        bd_write(4'd3, 32'hFFFFFFFF);
        bd_write(4'd7, 32'd10);

        // Requests during reset must be ignored
        set_req(0, 1'b1, 2'b01, 4'd2, 32'hAAAA5555);
        set_req(1, 1'b1, 2'b00, 4'd5, 32'h0);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_wea", 32'(mem_wea), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        req = '0;
        rstn = 1'b1;

        // Single read
        set_req(0, 1'b1, 2'b00, 4'd5, 32'h0);
        #1;
        chk("rd_gnt", 32'(gnt), 32'h1);
        chk("rd_addrb", 32'(mem_addrb), 32'd5);
        chk("rd_wea", 32'(mem_wea), 32'h0);
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid), 32'h1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);

        // Write then read back-to-back
        set_req(0, 1'b1, 2'b01, 4'd9, 32'h12345678);
        #1;
        chk("wr_gnt", 32'(gnt), 32'h1);
        chk("wr_wea", 32'(mem_wea), 32'h1);
        chk("wr_addra", 32'(mem_addra), 32'd9);
        chk("wr_dina", mem_dina, 32'h12345678);
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 4'd0, 32'h0);
        set_req(1, 1'b1, 2'b00, 4'd9, 32'h0);
        #1;
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        chk("rb_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        set_req(1, 1'b0, 2'b00, 4'd0, 32'h0);
        chk("rb_rvalid", 32'(rvalid), 32'h2);
        chk("rb_rdata", rdata, 32'h12345678);

        // Round-robin with both requesters holding reads
        set_req(0, 1'b1, 2'b00, 4'd5, 32'h0);
        set_req(1, 1'b1, 2'b00, 4'd9, 32'h0);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                chk("rr_rvalid", 32'(rvalid), (k % 2 == 0) ? 32'h2 : 32'h1);
                chk("rr_rdata", rdata, (k % 2 == 0) ? 32'h12345678 : 32'hDEADBEEF);
            end
            @(negedge clk);
        end
        req = '0;
        chk("rr_last_rvalid", 32'(rvalid), 32'h2);

        // Fetch-add with wrap; a read of the same word waits out the write-back
        set_req(1, 1'b1, 2'b10, 4'd3, 32'd2);
        #1;
        chk("fa_gnt", 32'(gnt), 32'h2);
        chk("fa_addrb", 32'(mem_addrb), 32'd3);
        chk("fa_wea0", 32'(mem_wea), 32'h0);
        @(negedge clk);
        set_req(1, 1'b0, 2'b00, 4'd0, 32'h0);
        set_req(0, 1'b1, 2'b00, 4'd3, 32'h0);
        #1;
        chk("fa_wb_gnt", 32'(gnt), 32'h0);
        chk("fa_rvalid", 32'(rvalid), 32'h2);
        chk("fa_old", rdata, 32'hFFFFFFFF);
        chk("fa_wea1", 32'(mem_wea), 32'h1);
        chk("fa_addra", 32'(mem_addra), 32'd3);
        chk("fa_dina", mem_dina, 32'h1);
        @(negedge clk);
        #1;
        chk("fa_rd_gnt", 32'(gnt), 32'h1);
        chk("fa_rd_idle", 32'(rvalid), 32'h0);
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 4'd0, 32'h0);
        chk("fa_rd_rvalid", 32'(rvalid), 32'h1);
        chk("fa_rd_rdata", rdata, 32'h1);

        // Contended fetch-add; a dummy read by requester 1 brings the pointer back to 0
        set_req(1, 1'b1, 2'b00, 4'd0, 32'h0);
        #1;
        chk("cfa_dummy_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        set_req(0, 1'b1, 2'b10, 4'd0, 32'd1);
        set_req(1, 1'b1, 2'b10, 4'd0, 32'd1);
        #1;
        chk("cfa_gnt0", 32'(gnt), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 4'd0, 32'h0);
        #1;
        chk("cfa_wb0_gnt", 32'(gnt), 32'h0);
        chk("cfa_rvalid0", 32'(rvalid), 32'h1);
        chk("cfa_old0", rdata, 32'h0);
        chk("cfa_dina0", mem_dina, 32'h1);
        @(negedge clk);
        #1;
        chk("cfa_gnt1", 32'(gnt), 32'h2);
        @(negedge clk);
        set_req(1, 1'b0, 2'b00, 4'd0, 32'h0);
        #1;
        chk("cfa_wb1_gnt", 32'(gnt), 32'h0);
        chk("cfa_rvalid1", 32'(rvalid), 32'h2);
        chk("cfa_old1", rdata, 32'h1);
        chk("cfa_dina1", mem_dina, 32'h2);
        @(negedge clk);
        chk("cfa_final", mem[0], 32'h2);

        // Reset during the write-back cycle abandons the write
        set_req(0, 1'b1, 2'b10, 4'd7, 32'd5);
        #1;
        chk("rfa_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 4'd0, 32'h0);
        #1;
        chk("rfa_wea_before", 32'(mem_wea), 32'h1);
        rstn = 1'b0;
        #1;
        chk("rfa_wea_rst", 32'(mem_wea), 32'h0);
        chk("rfa_rvalid_rst", 32'(rvalid), 32'h0);
        chk("rfa_gnt_rst", 32'(gnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        set_req(0, 1'b1, 2'b00, 4'd7, 32'h0);
        #1;
        chk("rfa_rd_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 2'b00, 4'd0, 32'h0);
        chk("rfa_rd_rvalid", 32'(rvalid), 32'h1);
        chk("rfa_rd_rdata", rdata, 32'd10);

        // Random traffic against a sequentially-consistent memory model
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom();
            bd_write(AW'(i), ref_mem[i]);
        end
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; r_op[i] = 2'b00; r_addr[i] = '0; r_wd[i] = '0;
        end
        model_ptr  = 0;
        model_busy = 1'b0;
        exp_rv     = '0;
        exp_rd     = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_rvalid", 32'(rvalid), 32'(exp_rv));
            if (exp_rv != '0) chk("rnd_rdata", rdata, exp_rd);
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i]   = 1'b1;
                        r_op[i]   = 2'($urandom_range(0, 3));
                        r_addr[i] = AW'($urandom_range(0, 15));
                        r_wd[i]   = $urandom();
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
                set_req(i, pend[i], r_op[i], r_addr[i], r_wd[i]);
            end
            #1;
            g = -1;
            if (!model_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && pend[(model_ptr + k) % N]) g = (model_ptr + k) % N;
                end
            end
            exp_g = (g >= 0) ? (N'(1) << g) : '0;
            chk("rnd_gnt", 32'(gnt), 32'(exp_g));
            exp_rv = '0;
            if (model_busy) begin
                model_busy = 1'b0;
            end else if (g >= 0) begin
                model_ptr = (g + 1) % N;
                pend[g]   = 1'b0;
                if (r_op[g] == 2'b01) begin
                    ref_mem[r_addr[g]] = r_wd[g];
                end else begin
                    exp_rv = N'(1) << g;
                    exp_rd = ref_mem[r_addr[g]];
                    if (r_op[g] == 2'b10) begin
                        ref_mem[r_addr[g]] = ref_mem[r_addr[g]] + r_wd[g];
                        model_busy = 1'b1;
                    end
                end
            end
            @(negedge clk);
        end
        req = '0;
        chk("rnd_tail_rvalid", 32'(rvalid), 32'(exp_rv));
        if (exp_rv != '0) chk("rnd_tail_rdata", rdata, exp_rd);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) chk("rnd_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
